// File: rtl/ram_wr_pack_pkg.sv
// ram_wr_pack_pkg: shared definitions for the result-RAM packing writer.
// Holds the element-mode encoding, the controller state enum and the
// lane-count helper used by ram_wr_pack and ram_wr_pack_fmt.
package ram_wr_pack_pkg;

  // Element-size encoding on i_elem_mode
  localparam logic [1:0] MODE_B8      = 2'b00;
  localparam logic [1:0] MODE_B16     = 2'b01;
  localparam logic [1:0] MODE_B32     = 2'b10;
  localparam logic [1:0] MODE_B32_ALT = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of element lanes in one WIDTH-bit word for a given mode
  function automatic int unsigned lane_count(input logic [1:0] mode,
                                             input int unsigned width);
    case (mode)
      MODE_B8:  return width / 8;
      MODE_B16: return width / 16;
      default:  return width / 32;
    endcase
  endfunction

endpackage

// File: rtl/ram_wr_pack_if.sv
// ram_wr_pack_if: NPU result stream inputs and BRAM/status outputs of the
// packing writer, bundled so the DUT and its driver share one definition.
// The slave modport is the writer's view; master is the producer/observer.
interface ram_wr_pack_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  // Result stream from the NPU
  logic                    i_write;
  logic                    i_term;
  logic [1:0]              i_elem_mode;
  logic [31:0]             i_data;
  logic                    i_data_valid;

  // BRAM port and status
  logic                    o_rst_ram;
  logic                    o_en_ram;
  logic [WIDTH/8-1:0]      o_wr_ram;
  logic [ADDR_WIDTH-1:0]   o_ram_addr;
  logic [WIDTH-1:0]        o_ram_data;
  logic                    o_busy;
  logic                    o_done;
  logic [15:0]             o_word_count;

  modport master (
    output i_write, i_term, i_elem_mode, i_data, i_data_valid,
    input  o_rst_ram, o_en_ram, o_wr_ram, o_ram_addr, o_ram_data,
           o_busy, o_done, o_word_count
  );

  modport slave (
    input  i_write, i_term, i_elem_mode, i_data, i_data_valid,
    output o_rst_ram, o_en_ram, o_wr_ram, o_ram_addr, o_ram_data,
           o_busy, o_done, o_word_count
  );

endinterface

// File: rtl/ram_wr_pack_fmt.sv
// ram_wr_pack_fmt: combinational element formatter. Reduces a 32-bit signed
// NPU result to the lane width selected by mode_i; the lane value is returned
// zero-extended in lane_o. 32-bit modes pass the data through unchanged.
// Optional feature macro: RAM_WR_PACK_SATURATE_EN (clamp instead of truncate).
module ram_wr_pack_fmt
  import ram_wr_pack_pkg::*;
(
  input  logic [1:0]  mode_i,
  input  logic [31:0] data_i,
  output logic [31:0] lane_o
);

  logic [7:0]  val8;
  logic [15:0] val16;

`ifdef RAM_WR_PACK_SATURATE_EN
  // Clamp to the signed range of the narrow element
  always_comb begin
    val8  = data_i[7:0];
    val16 = data_i[15:0];
    if ($signed(data_i) > 32'sd127) begin
      val8 = 8'h7F;
    end else if ($signed(data_i) < -32'sd128) begin
      val8 = 8'h80;
    end
    if ($signed(data_i) > 32'sd32767) begin
      val16 = 16'h7FFF;
    end else if ($signed(data_i) < -32'sd32768) begin
      val16 = 16'h8000;
    end
  end
`else
  // Keep only the low bits of the element
  always_comb begin
    val8  = data_i[7:0];
    val16 = data_i[15:0];
  end
`endif

  // Pick the lane value for the active element size
  always_comb begin
    lane_o = data_i;
    case (mode_i)
      MODE_B8:  lane_o = {24'd0, val8};
      MODE_B16: lane_o = {16'd0, val16};
      default:  lane_o = data_i;
    endcase
  end

endmodule

// File: rtl/ram_wr_pack.sv
// ram_wr_pack: packs 8/16/32-bit NPU results little-endian into WIDTH-bit
// words and writes them sequentially to a BRAM port with byte strobes,
// flushing a partial word when the session terminates.
// Optional feature macro: RAM_WR_PACK_SATURATE_EN (handled in ram_wr_pack_fmt).
module ram_wr_pack
  import ram_wr_pack_pkg::*;
#(
  parameter int unsigned            WIDTH      = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
)(
  input  logic           i_clk,
  input  logic           i_n_reset,
  ram_wr_pack_if.slave   bus
);

  localparam int unsigned NB     = WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(NB) + 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(NB);

  // Controller and packing accumulator
  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [15:0]            cnt_q, cnt_d;

  // Write register, kept apart from the accumulator so packing never stalls
  logic                   en_q, en_d;
  logic [NB-1:0]          strb_q, strb_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic                   rst_ram_q;

  // Formatted element and the accumulator as it looks after this cycle's element
  logic [31:0]            fmt_val;
  logic [LANE_W-1:0]      lane_lim;
  logic                   accept;
  logic [LANE_W-1:0]      lane_n;
  logic [WIDTH-1:0]       acc_n;
  logic [NB-1:0]          strb_n;
  logic                   word_full;
  logic                   flush_wr;
  logic                   do_write;

  ram_wr_pack_fmt u_fmt (
    .mode_i (mode_q),
    .data_i (bus.i_data),
    .lane_o (fmt_val)
  );

  assign lane_lim  = LANE_W'(lane_count(mode_q, WIDTH));
  assign accept    = (state_q == PACK) && bus.i_data_valid;
  assign lane_n    = accept ? lane_q + LANE_W'(1) : lane_q;
  assign word_full = accept && (lane_n == lane_lim);
  // The partial word is captured on the same edge that enters FLUSH so its
  // write pulse lands in the FLUSH cycle; a completed word needs no extra write.
  assign flush_wr  = (state_q == PACK) && bus.i_term && !word_full && (lane_n != '0);
  assign do_write  = word_full || flush_wr;

  // Per-byte lane mapping: which lane owns the byte, and which slice of the
  // formatted element lands there. A byte's strobe is set once its lane is filled.
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    logic [LANE_W-1:0] byte_lane;
    logic [7:0]        byte_src;

    // Lane ownership and source slice of this byte for the latched mode
    always_comb begin
      byte_lane = LANE_W'(gi / 4);
      byte_src  = fmt_val[(gi % 4) * 8 +: 8];
      case (mode_q)
        MODE_B8: begin
          byte_lane = LANE_W'(gi);
          byte_src  = fmt_val[7:0];
        end
        MODE_B16: begin
          byte_lane = LANE_W'(gi / 2);
          byte_src  = fmt_val[(gi % 2) * 8 +: 8];
        end
        default: begin
          byte_lane = LANE_W'(gi / 4);
          byte_src  = fmt_val[(gi % 4) * 8 +: 8];
        end
      endcase
    end

    assign acc_n[gi*8 +: 8] = (accept && (byte_lane == lane_q)) ? byte_src : acc_q[gi*8 +: 8];
    assign strb_n[gi]       = (byte_lane < lane_n);
  end

  // Next-state logic: session control, packing and write-register loading
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    strb_d  = '0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;

    case (state_q)
      IDLE: begin
        if (bus.i_write) begin
          mode_d  = bus.i_elem_mode;
          lane_d  = '0;
          acc_d   = '0;
          cnt_d   = '0;
          addr_d  = BASE_ADDR;
          state_d = PACK;
        end
      end
      PACK: begin
        acc_d  = acc_n;
        lane_d = lane_n;
        if (do_write) begin
          en_d    = 1'b1;
          strb_d  = strb_n;
          wdata_d = acc_n;
          waddr_d = addr_q;
          addr_d  = addr_q + WORD_STEP;
          cnt_d   = cnt_q + 16'd1;
          acc_d   = '0;
          lane_d  = '0;
        end
        if (bus.i_term) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        if (!bus.i_write) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and write-register update
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_B8;
      lane_q  <= '0;
      acc_q   <= '0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      waddr_q <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  // BRAM reset is held through reset and released on the first clock after it
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      rst_ram_q <= 1'b1;
    end else begin
      rst_ram_q <= 1'b0;
    end
  end

  assign bus.o_rst_ram    = rst_ram_q;
  assign bus.o_en_ram     = en_q;
  assign bus.o_wr_ram     = strb_q;
  assign bus.o_ram_addr   = waddr_q;
  assign bus.o_ram_data   = wdata_q;
  assign bus.o_busy       = (state_q == PACK) || (state_q == FLUSH);
  assign bus.o_done       = (state_q == DONE);
  assign bus.o_word_count = cnt_q;

endmodule

// File: tb/tb_ram_wr_pack.sv
// tb_ram_wr_pack: randomized scoreboard bench for ram_wr_pack (WIDTH=64,
// BASE_ADDR=0x100). The driver feeds elements and a reference model turns the
// element stream into expected BRAM writes; a monitor compares each write.
module tb_ram_wr_pack;

  localparam int TW = 64;
  localparam int NB = TW / 8;
  localparam logic [31:0] BASE = 32'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_wr_pack_if #(.WIDTH(TW), .ADDR_WIDTH(32)) bus ();

  ram_wr_pack #(.WIDTH(TW), .ADDR_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .i_clk     (clk),
    .i_n_reset (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   addr;
    logic [TW-1:0] data;
    logic [NB-1:0] strb;
    logic [15:0]   cnt;
    int            due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dir_q[$];
  logic [31:0] m_cur[$];
  logic [31:0] m_addr;
  int          m_cnt;
  int          m_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Element value reduced to E bits by the spec rules (clamp or truncate)
  function automatic logic [31:0] model_fmt(input int e, input logic [31:0] d);
    int v;
    v = $signed(d);
    if (e == 32) return d;
`ifdef RAM_WR_PACK_SATURATE_EN
    if (e == 8) begin
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
    end else begin
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
    end
`endif
    return 32'(v) & ((32'd1 << e) - 32'd1);
  endfunction

  // Turn the collected elements into one expected write
  task automatic model_emit(input int due);
    exp_t x;
    logic [TW-1:0] w;
    x.data = '0;
    x.strb = '0;
    for (int k = 0; k < m_cur.size(); k++) begin
      w = '0;
      w[31:0] = m_cur[k];
      x.data = x.data | (w << (k * m_e));
      for (int b = 0; b < m_e / 8; b++) x.strb[k * (m_e / 8) + b] = 1'b1;
    end
    m_cnt++;
    x.addr = m_addr;
    x.cnt  = 16'(m_cnt);
    x.due  = due;
    exp_q.push_back(x);
    m_cur.delete();
    m_addr = m_addr + NB;
  endtask

  // Monitor: every write pulse must match the head of the scoreboard
  always @(negedge clk) begin : mon
    exp_t x;
    if (rst_n && bus.o_en_ram) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", bus.o_ram_addr, bus.o_ram_data);
      end else begin
        x = exp_q.pop_front();
        chk("wr_addr", bus.o_ram_addr, x.addr);
        chk("wr_data", bus.o_ram_data, x.data);
        chk("wr_strb", bus.o_wr_ram, x.strb);
        chk("wr_count", bus.o_word_count, x.cnt);
        chk("wr_cycle", cyc, x.due);
      end
    end else if (rst_n) begin
      chk("idle_strb", bus.o_wr_ram, '0);
    end
  end

  function automatic logic [31:0] rnd_data();
    int v;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin v = int'($urandom_range(0, 600)) - 300; return 32'(v); end
      2: begin v = int'($urandom_range(0, 80000)) - 40000; return 32'(v); end
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  // Start a session; returns at the first negedge in PACK
  task automatic start_session(input logic [1:0] mode);
    @(negedge clk);
    bus.i_write = 1'b1;
    bus.i_elem_mode = mode;
    bus.i_data_valid = 1'b1;     // must be ignored in IDLE
    bus.i_data = $urandom;
    m_e = (mode == 2'b00) ? 8 : (mode == 2'b01) ? 16 : 32;
    m_addr = BASE;
    m_cnt = 0;
    m_cur.delete();
    @(negedge clk);
    bus.i_write = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_elem_mode = ~mode;     // mid-session change must have no effect
    chk("start_busy", bus.o_busy, 1'b1);
  endtask

  // Drive one cycle of stream input and record the expected outcome
  task automatic feed(input logic valid, input logic [31:0] d, input logic term);
    bus.i_data_valid = valid;
    bus.i_data = d;
    bus.i_term = term;
    if (valid) begin
      m_cur.push_back(model_fmt(m_e, d));
      if (m_cur.size() == TW / m_e) model_emit(cyc + 1);
    end
    if (term && m_cur.size() != 0) model_emit(cyc + 1);
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    bus.i_term = 1'b0;
  endtask

  // Called in the FLUSH cycle; checks completion and returns to IDLE
  task automatic finish_session();
    chk("flush_busy", bus.o_busy, 1'b1);
    chk("flush_done", bus.o_done, 1'b0);
    @(negedge clk);
    chk("done", bus.o_done, 1'b1);
    chk("done_busy", bus.o_busy, 1'b0);
    chk("word_count", bus.o_word_count, 16'(m_cnt));
    chk("pending_writes", exp_q.size(), 0);
    bus.i_write = 1'b1;
    @(negedge clk);
    chk("done_hold", bus.o_done, 1'b1);
    bus.i_write = 1'b0;
    bus.i_data_valid = 1'b1;     // ignored in DONE
    bus.i_data = $urandom;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    chk("idle_done", bus.o_done, 1'b0);
    chk("idle_busy", bus.o_busy, 1'b0);
  endtask

  task automatic run_session(input logic [1:0] mode, input int n);
    logic v;
    logic t;
    start_session(mode);
    if (dir_q.size() != 0) begin
      while (dir_q.size() != 0) begin
        t = (dir_q.size() == 1);
        feed(1'b1, dir_q.pop_front(), t);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        t = (i == n - 1);
        v = t ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) < 7);
        feed(v, rnd_data(), t);
      end
    end
    finish_session();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"}, bus.o_en_ram, 1'b0);
    chk({tag, "_wr"}, bus.o_wr_ram, '0);
    chk({tag, "_rst_ram"}, bus.o_rst_ram, 1'b1);
    chk({tag, "_addr"}, bus.o_ram_addr, BASE);
    chk({tag, "_data"}, bus.o_ram_data, '0);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    chk({tag, "_done"}, bus.o_done, 1'b0);
    chk({tag, "_count"}, bus.o_word_count, 16'd0);
  endtask

  initial begin
    bus.i_write = 1'b0;
    bus.i_term = 1'b0;
    bus.i_elem_mode = 2'b00;
    bus.i_data = '0;
    bus.i_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ram_release", bus.o_rst_ram, 1'b0);

    // 8-bit: term with the word-completing element -> one full write only
    for (int i = 1; i <= 8; i++) dir_q.push_back(32'(i));
    run_session(2'b00, 0);
    // 16-bit: partial word of three lanes
    dir_q.push_back(32'h1234); dir_q.push_back(32'hABCD); dir_q.push_back(32'h5555);
    run_session(2'b01, 0);
    // 8-bit out-of-range values: clamp or truncate
    dir_q.push_back(32'd300); dir_q.push_back(-32'sd200);
    run_session(2'b00, 0);
    // 32-bit: two full words from the base address
    dir_q.push_back(32'hA); dir_q.push_back(32'hB); dir_q.push_back(32'hC); dir_q.push_back(32'hD);
    run_session(2'b10, 0);

    // Reset in the middle of a session discards the partial word
    start_session(2'b00);
    feed(1'b1, 32'd5, 1'b0);
    feed(1'b1, 32'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    m_cur.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ram_release2", bus.o_rst_ram, 1'b0);

    for (int s = 0; s < 40; s++) begin
      run_session(2'($urandom_range(0, 3)), int'($urandom_range(1, 24)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_wr_pack.md
# ram_wr_pack

Parametrised result-RAM writer that packs narrow NPU results (8-, 16- or 32-bit elements) into WIDTH-bit words and writes them sequentially to a BRAM port with per-byte write strobes. It flushes a partially filled word when the session terminates. It sits between the NPU result stream (data/valid/write/term) and the result BRAM. It succeeds the one-result-per-word writer by adding configurable word width, element packing, partial-word flush, a base address and a completion flag.

## Interface
Parameters:
- WIDTH, 32, BRAM word width in bits; must be a multiple of 32 (32, 64, 128).
- ADDR_WIDTH, 32, width of the byte address.
- BASE_ADDR, 0, byte address of the first word written in a session.

Ports:
- i_clk  in  1  single clock; all logic is rising-edge.
- i_n_reset  in  1  asynchronous, active-low reset.
- i_write  in  1  session enable; high in IDLE starts a session.
- i_term  in  1  ends the session and flushes any partial word.
- i_elem_mode  in  2  element size: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = 32-bit. Latched at session start.
- i_data  in  32  signed result element.
- i_data_valid  in  1  element strobe; accepted only in PACK.
- o_rst_ram  out  1  BRAM reset.
- o_en_ram  out  1  BRAM enable; one-cycle pulse per word written.
- o_wr_ram  out  WIDTH/8  byte write strobes; valid with o_en_ram.
- o_ram_addr  out  ADDR_WIDTH  byte address of the current write.
- o_ram_data  out  WIDTH  packed word.
- o_busy  out  1  high in PACK and FLUSH.
- o_done  out  1  high in DONE.
- o_word_count  out  16  number of words written this session; wraps modulo 2^16.

## Operation
- Element size E is 8, 16 or 32 bits. The number of lanes per word is WIDTH/E.
- Packing is little-endian: lane k occupies bits [k*E +: E]. Each lane maps to E/8 byte strobes.
- State machine:
  - IDLE: when i_write = 1, latch the mode, clear the lane index, the word count and the address (set address to BASE_ADDR), then go to PACK.
  - PACK: on each i_data_valid, format the element (see Configuration) into the current lane and advance the lane index.
    - When the last lane fills, hand the full word to the write register. Strobes are all ones.
    - Then clear the lane index, add WIDTH/8 to the address, and increment the word count.
    - On i_term, go to FLUSH.
  - FLUSH: if the lane index is nonzero, write the partial word. Unfilled lanes are zero and their strobes are zero. Then go to DONE. If the lane index is zero, go straight to DONE with no write.
  - DONE: o_done = 1. Hold until i_write = 0, then go to IDLE.
- i_data_valid together with i_term in PACK: accept the element first, then flush. If that element completes a word, the full word is written and FLUSH performs no extra write.
- i_data_valid outside PACK is ignored.
- Changing i_elem_mode mid-session has no effect.
- The address wraps naturally modulo 2^ADDR_WIDTH.
- Reset mid-operation: the partial word is discarded, no write is issued, and all outputs return to their reset values.

## Timing
- Reset values:
  - o_rst_ram = 1, dropping to 0 on the first clock edge after reset release.
  - All other outputs = 0.
  - o_ram_addr = BASE_ADDR.
- Write latency: o_en_ram and o_wr_ram are asserted in the cycle after the clock edge that accepts the word-completing element. They are registered and last exactly one cycle.
- o_ram_addr and o_ram_data are stable in the o_en_ram cycle.
- Throughput: one element per cycle, sustained. The write register is separate from the packing accumulator, so the next word packs while the previous one is being written. No backpressure.
- FLUSH write: asserted the cycle after the edge that enters FLUSH.
- o_done: rises one cycle after the last write, or one cycle after FLUSH if there was no write.

## Configuration
- RAM_WR_PACK_SATURATE_EN defined: 8- and 16-bit elements are clamped to the signed range of E (8-bit: [-128, 127]; 16-bit: [-32768, 32767]) before packing.
- RAM_WR_PACK_SATURATE_EN undefined: the low E bits are taken (truncation).
- 32-bit mode is unaffected either way.

## Structure
- Package ram_wr_pack_pkg contains:
  - the element-mode encoding constants;
  - the state enum (IDLE, PACK, FLUSH, DONE);
  - a function giving the lane count from mode and WIDTH.
- Sub-module ram_wr_pack_fmt: combinational saturate/truncate formatter, 32-bit signed input to E-bit lane value. It holds the only RAM_WR_PACK_SATURATE_EN conditional.

## Test plan
- WIDTH=32, mode 00, feed 1, 2, 3, 4 on consecutive cycles -> one write: addr 0x0, data 0x04030201, strobes 4'hF, one cycle after the 4th valid; o_word_count = 1.
- Mode 01, feed 0x1234, 0xABCD, 0x5555, then i_term ->
  - addr 0x0, data 0xABCD1234, strobes 4'hF;
  - addr 0x4, data 0x00005555, strobes 4'b0011;
  - then o_done = 1.
- Mode 00, feed 300, then -200 ->
  - with the macro defined: lanes 0x7F, 0x80;
  - without the macro: lanes 0x2C, 0x38.
- Mode 00, i_term asserted together with the 4th element -> exactly one full write, no flush write, o_done one cycle later.
- Reset asserted after 2 elements in mode 00 -> no o_en_ram pulse, outputs at reset values; the next session's first write goes to BASE_ADDR.
- WIDTH=64, BASE_ADDR=0x100, mode 10, feed 0xA, 0xB, 0xC, 0xD ->
  - addr 0x100, data {0xB, 0xA}, strobes 8'hFF;
  - addr 0x108, data {0xD, 0xC}, strobes 8'hFF.
